// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one slow block memory between an I-cache and a D-cache port.
// Define MEM_ARBITER_RR_EN for round-robin on contention; by default D always wins.
module mem_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_read,
    input  logic         i_write,
    input  logic [27:0]  i_addr,
    input  logic [127:0] i_wdata,
    output logic [127:0] i_rdata,
    output logic         i_ready,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [27:0]  d_addr,
    input  logic [127:0] d_wdata,
    output logic [127:0] d_rdata,
    output logic         d_ready,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready,
    output logic [15:0]  wait_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SERVE_I = 2'd1,
        S_SERVE_D = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t       r_state;
    logic         r_rel_d;
    logic         r_i_ready;
    logic         r_d_ready;
    logic [127:0] r_i_rdata;
    logic [127:0] r_d_rdata;
    logic [15:0]  r_wait_cnt;

    logic w_i_pend;
    logic w_d_pend;
    logic w_rr_d;
    logic w_pick_d;
    logic w_stall;

    assign w_i_pend = i_read | i_write;
    assign w_d_pend = d_read | d_write;
    assign w_pick_d = w_d_pend & (~w_i_pend | w_rr_d);

`ifdef MEM_ARBITER_RR_EN
    // r_last_d set means the most recent grant went to D
    logic r_last_d;

    assign w_rr_d = ~r_last_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d <= 1'b0;
        end else if (r_state == S_IDLE && (w_i_pend || w_d_pend)) begin
            r_last_d <= w_pick_d;
        end
    end
`else
    assign w_rr_d = 1'b1;
`endif

    // The loser of arbitration is whoever is pending but not being served
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_SERVE_I: w_stall = w_d_pend;
            S_SERVE_D: w_stall = w_i_pend;
            S_RELEASE: w_stall = r_rel_d ? w_i_pend : w_d_pend;
            default:   w_stall = 1'b0;
        endcase
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 28'd0;
        mem_wdata = 128'd0;
        case (r_state)
            S_SERVE_I: begin
                mem_write = i_write;
                mem_read  = i_read & ~i_write;
                mem_addr  = i_addr;
                mem_wdata = i_wdata;
            end
            S_SERVE_D: begin
                mem_write = d_write;
                mem_read  = d_read & ~d_write;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end
            default: begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rel_d    <= 1'b0;
            r_i_ready  <= 1'b0;
            r_d_ready  <= 1'b0;
            r_i_rdata  <= 128'd0;
            r_d_rdata  <= 128'd0;
            r_wait_cnt <= 16'd0;
        end else begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            if (w_stall && r_wait_cnt != 16'hFFFF) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pick_d) begin
                        r_state <= S_SERVE_D;
                    end else if (w_i_pend) begin
                        r_state <= S_SERVE_I;
                    end
                end
                S_SERVE_I: begin
                    if (!w_i_pend) begin
                        r_state <= S_IDLE;
                    end else if (mem_ready) begin
                        r_i_rdata <= mem_rdata;
                        r_i_ready <= 1'b1;
                        r_rel_d   <= 1'b0;
                        r_state   <= S_RELEASE;
                    end
                end
                S_SERVE_D: begin
                    if (!w_d_pend) begin
                        r_state <= S_IDLE;
                    end else if (mem_ready) begin
                        r_d_rdata <= mem_rdata;
                        r_d_ready <= 1'b1;
                        r_rel_d   <= 1'b1;
                        r_state   <= S_RELEASE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign i_ready  = r_i_ready;
    assign d_ready  = r_d_ready;
    assign i_rdata  = r_i_rdata;
    assign d_rdata  = r_d_rdata;
    assign wait_cnt = r_wait_cnt;

endmodule
